pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Hazard and stall controller for the 5-stage pipeline. It sits directly upstream of the bypass network, in the decode/execute boundary, and decides whether the FD and DX latches advance, hold, or receive a bubble. Bypassing handles every hazard it can; this block stalls only for the hazards bypassing cannot resolve:

- load-use dependences;
- multi-cycle mult/div occupancy;
- decode-resolved control-flow squashes.

## Interface
Parameters:
- MD_TIMEOUT, 40: maximum cycles a mult/div may stay busy before `md_err` asserts.
- CNT_W, 32: width of the saturating stall-cycle counter.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- FD_rs, FD_rt  in  5 each  source registers of the instruction in decode.
- FD_usesRt  in  1  decode instruction reads rt. R-type, sw, bne and blt assert it.
- DX_rd  in  5  destination register of the instruction in execute.
- DX_MemToReg  in  1  execute instruction is a load.
- DX_isMult, DX_isDiv  in  1 each  execute instruction is mul or div.
- md_ready  in  1  mult/div unit result valid, one-cycle pulse.
- md_exception  in  1  mult/div unit exception, qualified by md_ready.
- br_taken  in  1  decode resolved a taken branch, j, jal, jr or bex.
- pc_en  out  1  PC register write enable.
- fd_en  out  1  FD latch write enable.
- fd_flush  out  1  FD latch loads a nop.
- dx_bubble  out  1  DX latch loads a nop.
- ctrl_MULT, ctrl_DIV  out  1 each  single-cycle start pulses to the mult/div unit.
- md_busy  out  1  mult/div in flight.
- md_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
FSM states: IDLE, START, BUSY, DONE.

Transitions:
- IDLE → START when DX_isMult or DX_isDiv is high. Only one of the two is ever high.
- START: drives exactly one of ctrl_MULT or ctrl_DIV for this one cycle. The opcode is latched on entry. Goes to BUSY.
- BUSY → DONE on md_ready.
- DONE: one cycle. The result is captured into XM; md_exception is forwarded by the datapath, not by this block. Goes to IDLE.

Mult/div busy counter:
- Cleared on entry to START; increments each cycle in BUSY.
- When it reaches MD_TIMEOUT: md_err sets and is sticky until reset, and the FSM is forced to DONE.

md_busy is high in START and BUSY.

Load-use hazard, `lu`: DX_MemToReg & (DX_rd≠0) & ((DX_rd==FD_rs) | (FD_usesRt & DX_rd==FD_rt)).

Output priority, highest first:
1. Reset.
2. md_busy: pc_en=0, fd_en=0, dx_bubble=0. DX holds, so the mult/div instruction stays in execute.
3. lu: pc_en=0, fd_en=0, dx_bubble=1.
4. br_taken: pc_en=1, fd_en=1, fd_flush=1, dx_bubble=0.
5. Otherwise: pc_en=1, fd_en=1, others 0.

Rules for simultaneous events:
- br_taken is ignored while md_busy or lu is high. The branch re-resolves after the stall.
- DONE cycle: the pipeline advances normally. A back-to-back mult/div arriving in DX then re-enters START on the next edge.

stall_cnt increments on every cycle with pc_en=0 and saturates at all-ones.

## Timing
Reset values (all while reset_n is low, asynchronous):
- FSM = IDLE, counters = 0, md_err = 0.
- pc_en = fd_en = 1; fd_flush = dx_bubble = ctrl_MULT = ctrl_DIV = 0.

Combinational paths and latency:
- lu and br_taken responses are combinational, same cycle.
- ctrl_* rises in the cycle after DX_isMult/DX_isDiv is first seen in IDLE.
- md_busy is registered from FSM state.
- Minimum mult/div occupancy: START, then BUSY with md_ready in its first cycle, then DONE. That is 3 stall-free-return cycles: stalled for 2, advancing on DONE.

Boundary conditions:
- An md_ready that arrives in START is ignored.
- If reset_n falls mid-BUSY, the FSM returns to IDLE immediately. The mult/div unit is reset by the same net.

## Structure
- Shared package `pipe_pkg`:
  - FSM state enum `md_state_t`;
  - opcode constants MULT and DIV;
  - constant REG_ZERO = 5'd0.
- One sub-module, `md_sequencer`: the FSM plus the timeout counter. It outputs md_busy, ctrl_* and md_err.
- The top level holds lu detection, the priority mux and stall_cnt.

## Test plan
- Load-use: `lw r5` in DX, `add r6,r5,r2` in FD → one cycle with pc_en=0, fd_en=0, dx_bubble=1; next cycle all advance.
- Rt-only use: `lw r5` in DX, `addi r7,r4` with FD_rt=5 and FD_usesRt=0 → no stall. Load to r0 with FD_rs=0 → no stall.
- Mult: DX_isMult, md_ready 17 cycles after ctrl_MULT → ctrl_MULT is high for exactly 1 cycle, md_busy for 18 cycles, stall_cnt += 18.
- Taken branch while lu is high → fd_flush=0, stall applied. Next cycle, br_taken alone → fd_flush=1, pc_en=1.
- Timeout: md_ready withheld → md_err=1 after MD_TIMEOUT BUSY cycles, FSM passes DONE then IDLE, md_err stays 1 until reset_n pulses low.
- Async reset mid-BUSY: reset_n low between clock edges → outputs take reset values immediately and stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Latency: none, declarations and a pure combinational helper only.
// Backpressure: none.
package pipe_pkg;

    // Mult/div sequencer states. START is the single start-pulse cycle,
    // BUSY waits for the unit, DONE is the one-cycle result capture.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } md_state_t;

    // Opcode latched when a mult/div is accepted; selects which start
    // strobe is driven in START.
    localparam logic MULT = 1'b0;
    localparam logic DIV  = 1'b1;

    // Writes to r0 are discarded, so they never create a dependence.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load-use dependence between the load in execute and the
    // instruction in decode. The rt comparison only counts when the
    // decode instruction actually reads rt (I-type rt is a destination).
    function automatic logic load_use_hazard(
        input logic       dx_mem_to_reg,
        input logic [4:0] dx_rd,
        input logic [4:0] fd_rs,
        input logic [4:0] fd_rt,
        input logic       fd_uses_rt
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = (dx_rd == fd_rs);
        rt_hit = fd_uses_rt && (dx_rd == fd_rt);
        return dx_mem_to_reg && (dx_rd != REG_ZERO) && (rs_hit || rt_hit);
    endfunction

endpackage : pipe_pkg

// File: rtl/md_sequencer.sv
// Mult/div sequencer: issues the start pulse, tracks occupancy, flags timeouts.
// Latency: start pulse one cycle after the opcode is seen in IDLE; busy is decoded from registered state.
// Backpressure: md_busy_o holds the pipeline for START and all BUSY cycles; md_ready_i in START is ignored.
module md_sequencer
    import pipe_pkg::*;
#(
    parameter int MD_TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset_n,
    input  logic is_mult_i,
    input  logic is_div_i,
    input  logic md_ready_i,
    output logic md_busy_o,
    output logic ctrl_mult_o,
    output logic ctrl_div_o,
    output logic md_err_o
);

    // Counter wide enough to hold MD_TIMEOUT itself.
    localparam int TMO_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    md_state_t        state_q;
    md_state_t        state_d;
    logic             op_q;
    logic             op_d;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;

    // State, latched opcode, busy counter and sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= MULT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The counter counts completed BUSY cycles; when the
    // cycle that would make it MD_TIMEOUT ends without md_ready, the unit is
    // abandoned, the error latches and the FSM still passes through DONE so
    // the pipeline releases the same way as a normal completion.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (is_mult_i || is_div_i) begin
                    state_d = START;
                    op_d    = is_div_i ? DIV : MULT;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A ready pulse here cannot belong to this operation.
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + TMO_ONE;
                if (md_ready_i) begin
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                // Result captured into XM this cycle; a following mult/div
                // is picked up from IDLE once it reaches execute.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        md_busy_o   = (state_q == START) || (state_q == BUSY);
        ctrl_mult_o = (state_q == START) && (op_q == MULT);
        ctrl_div_o  = (state_q == START) && (op_q == DIV);
        md_err_o    = err_q;
    end

endmodule : md_sequencer

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller at the decode/execute boundary: PC/FD enables, FD flush, DX bubble.
// Latency: load-use and taken-branch responses are combinational; mult/div stall follows registered FSM state.
// Backpressure: mult/div occupancy outranks load-use, which outranks branch squash; stall cycles are counted.
module pipeline_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       FD_rs,
    input  logic [4:0]       FD_rt,
    input  logic             FD_usesRt,
    input  logic [4:0]       DX_rd,
    input  logic             DX_MemToReg,
    input  logic             DX_isMult,
    input  logic             DX_isDiv,
    input  logic             md_ready,
    input  logic             md_exception,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic             md_busy,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             lu;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // The exception travels with the result through the datapath; this
    // block only sequences the unit, so the input is intentionally dropped.
    logic md_exception_unused;
    assign md_exception_unused = md_exception;

    md_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_sequencer (
        .clock       (clock),
        .reset_n     (reset_n),
        .is_mult_i   (DX_isMult),
        .is_div_i    (DX_isDiv),
        .md_ready_i  (md_ready),
        .md_busy_o   (md_busy),
        .ctrl_mult_o (ctrl_MULT),
        .ctrl_div_o  (ctrl_DIV),
        .md_err_o    (md_err)
    );

    // Load-use dependence the bypass network cannot cover.
    always_comb begin
        lu = load_use_hazard(DX_MemToReg, DX_rd, FD_rs, FD_rt, FD_usesRt);
    end

    // Priority mux. While the mult/div is in flight DX holds (no bubble) so
    // the instruction stays in execute; a branch seen during any stall is
    // dropped and re-resolves once decode advances.
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        if (!reset_n) begin
            // Reset values regardless of what the datapath is presenting.
        end else if (md_busy) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
        end else if (lu) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
        end else if (br_taken) begin
            fd_flush = 1'b1;
        end
    end

    // Saturating increment of the stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule : pipeline_stall_ctrl

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for the pipeline stall controller.
// Inputs change just after the falling edge, outputs are sampled 1ns later.
// Output vector order: {pc_en, fd_en, fd_flush, dx_bubble, ctrl_MULT, ctrl_DIV, md_busy, md_err}.
module tb_pipeline_stall_ctrl;

    localparam int MD_TIMEOUT = 40;
    localparam int CNT_W      = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [4:0]       FD_rs;
    logic [4:0]       FD_rt;
    logic             FD_usesRt;
    logic [4:0]       DX_rd;
    logic             DX_MemToReg;
    logic             DX_isMult;
    logic             DX_isDiv;
    logic             md_ready;
    logic             md_exception;
    logic             br_taken;
    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic             dx_bubble;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             md_busy;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       outs;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign outs = {pc_en, fd_en, fd_flush, dx_bubble, ctrl_MULT, ctrl_DIV, md_busy, md_err};

    pipeline_stall_ctrl #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .FD_rs        (FD_rs),
        .FD_rt        (FD_rt),
        .FD_usesRt    (FD_usesRt),
        .DX_rd        (DX_rd),
        .DX_MemToReg  (DX_MemToReg),
        .DX_isMult    (DX_isMult),
        .DX_isDiv     (DX_isDiv),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .br_taken     (br_taken),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .fd_flush     (fd_flush),
        .dx_bubble    (dx_bubble),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_busy      (md_busy),
        .md_err       (md_err),
        .stall_cnt    (stall_cnt)
    );

    task automatic cyc;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs;
        FD_rs = 5'd0; FD_rt = 5'd0; FD_usesRt = 1'b0;
        DX_rd = 5'd0; DX_MemToReg = 1'b0;
        DX_isMult = 1'b0; DX_isDiv = 1'b0;
        md_ready = 1'b0; md_exception = 1'b0; br_taken = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_inputs();
        DX_MemToReg = 1'b1; DX_rd = 5'd5; FD_rs = 5'd5;
        @(negedge clock); #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, 8'b1100_0000); end
        checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        idle_inputs();
        @(negedge clock); reset_n = 1'b1; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL reset_release got=%b exp=%b", outs, 8'b1100_0000); end
    endtask

    task automatic test_load_use;
        // lw r5 in DX, add r6,r5,r2 in FD
        DX_MemToReg = 1'b1; DX_rd = 5'd5; FD_rs = 5'd5; FD_rt = 5'd2; FD_usesRt = 1'b1; #1;
        checks++; if (outs !== 8'b0001_0000) begin failures++; $display("FAIL lu_rs got=%b exp=%b", outs, 8'b0001_0000); end
        cyc();
        DX_MemToReg = 1'b0; DX_rd = 5'd0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL lu_release got=%b exp=%b", outs, 8'b1100_0000); end
        checks++; if (stall_cnt !== 8'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        // dependence only through rt
        DX_MemToReg = 1'b1; DX_rd = 5'd5; FD_rs = 5'd3; FD_rt = 5'd5; FD_usesRt = 1'b1; #1;
        checks++; if (outs !== 8'b0001_0000) begin failures++; $display("FAIL lu_rt got=%b exp=%b", outs, 8'b0001_0000); end
        cyc();
        idle_inputs(); #1;
        checks++; if (stall_cnt !== 8'd2) begin failures++; $display("FAIL lu_rt_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_no_stall;
        // addi r7,r4: rt matches but is not read
        DX_MemToReg = 1'b1; DX_rd = 5'd5; FD_rs = 5'd4; FD_rt = 5'd5; FD_usesRt = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL rt_unused got=%b exp=%b", outs, 8'b1100_0000); end
        cyc();
        DX_rd = 5'd0; FD_rs = 5'd0; FD_rt = 5'd0; FD_usesRt = 1'b1; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL load_r0 got=%b exp=%b", outs, 8'b1100_0000); end
        cyc();
        DX_MemToReg = 1'b0; DX_rd = 5'd5; FD_rs = 5'd5; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL alu_dep got=%b exp=%b", outs, 8'b1100_0000); end
        cyc();
        idle_inputs(); #1;
        checks++; if (stall_cnt !== 8'd2) begin failures++; $display("FAIL no_stall_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_branch;
        DX_MemToReg = 1'b1; DX_rd = 5'd9; FD_rs = 5'd9; br_taken = 1'b1; #1;
        checks++; if (outs !== 8'b0001_0000) begin failures++; $display("FAIL br_under_lu got=%b exp=%b", outs, 8'b0001_0000); end
        cyc();
        DX_MemToReg = 1'b0; DX_rd = 5'd0; FD_rs = 5'd0; #1;
        checks++; if (outs !== 8'b1110_0000) begin failures++; $display("FAIL br_alone got=%b exp=%b", outs, 8'b1110_0000); end
        cyc();
        idle_inputs(); #1;
        checks++; if (stall_cnt !== 8'd3) begin failures++; $display("FAIL br_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_mult;
        int busy_n;
        int mult_n;
        int div_n;
        busy_n = 0; mult_n = 0; div_n = 0;
        DX_isMult = 1'b1; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL mult_seen got=%b exp=%b", outs, 8'b1100_0000); end
        // c=0 is START; md_ready 17 cycles later; c=18 is DONE
        for (int c = 0; c < 22; c++) begin
            cyc();
            md_ready  = (c == 17);
            DX_isMult = (c <= 18);
            #1;
            if (md_busy) busy_n++;
            if (ctrl_MULT) mult_n++;
            if (ctrl_DIV) div_n++;
            if (c == 0) begin
                checks++; if (outs !== 8'b0000_1010) begin failures++; $display("FAIL mult_start got=%b exp=%b", outs, 8'b0000_1010); end
            end
            if (c == 18) begin
                checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL mult_done got=%b exp=%b", outs, 8'b1100_0000); end
            end
        end
        checks++; if (busy_n != 18) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=18", busy_n); end
        checks++; if (mult_n != 1) begin failures++; $display("FAIL mult_pulse got=%0d exp=1", mult_n); end
        checks++; if (div_n != 0) begin failures++; $display("FAIL mult_no_div got=%0d exp=0", div_n); end
        checks++; if (stall_cnt !== 8'd21) begin failures++; $display("FAIL mult_cnt got=%0d exp=21", stall_cnt); end
    endtask

    task automatic test_back_to_back;
        DX_isDiv = 1'b1; #1;
        cyc();
        md_ready = 1'b1; #1;
        checks++; if (outs !== 8'b0000_0110) begin failures++; $display("FAIL div_start got=%b exp=%b", outs, 8'b0000_0110); end
        cyc();
        md_ready = 1'b0; #1;
        checks++; if (outs !== 8'b0000_0010) begin failures++; $display("FAIL div_ready_in_start got=%b exp=%b", outs, 8'b0000_0010); end
        cyc();
        md_ready = 1'b1; #1;
        checks++; if (outs !== 8'b0000_0010) begin failures++; $display("FAIL div_busy got=%b exp=%b", outs, 8'b0000_0010); end
        cyc();
        md_ready = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL div_done got=%b exp=%b", outs, 8'b1100_0000); end
        cyc();
        DX_isDiv = 1'b0; DX_isMult = 1'b1; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", outs, 8'b1100_0000); end
        cyc(); #1;
        checks++; if (outs !== 8'b0000_1010) begin failures++; $display("FAIL b2b_start got=%b exp=%b", outs, 8'b0000_1010); end
        cyc();
        md_ready = 1'b1; #1;
        checks++; if (outs !== 8'b0000_0010) begin failures++; $display("FAIL b2b_busy got=%b exp=%b", outs, 8'b0000_0010); end
        cyc();
        md_ready = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL b2b_done got=%b exp=%b", outs, 8'b1100_0000); end
        cyc();
        DX_isMult = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL b2b_idle_after got=%b exp=%b", outs, 8'b1100_0000); end
        checks++; if (stall_cnt !== 8'd26) begin failures++; $display("FAIL b2b_cnt got=%0d exp=26", stall_cnt); end
    endtask

    task automatic test_timeout;
        int bad;
        bad = 0;
        DX_isMult = 1'b1; #1;
        cyc(); #1;
        checks++; if (outs !== 8'b0000_1010) begin failures++; $display("FAIL to_start got=%b exp=%b", outs, 8'b0000_1010); end
        for (int k = 1; k <= MD_TIMEOUT; k++) begin
            cyc(); #1;
            if (outs !== 8'b0000_0010) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL to_busy_window bad_cycles got=%0d exp=0", bad); end
        cyc();
        DX_isMult = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0001) begin failures++; $display("FAIL to_done_err got=%b exp=%b", outs, 8'b1100_0001); end
        cyc(); #1;
        checks++; if (outs !== 8'b1100_0001) begin failures++; $display("FAIL to_idle_err got=%b exp=%b", outs, 8'b1100_0001); end
        cyc(); #1;
        checks++; if (outs !== 8'b1100_0001) begin failures++; $display("FAIL to_err_sticky got=%b exp=%b", outs, 8'b1100_0001); end
        checks++; if (stall_cnt !== 8'd67) begin failures++; $display("FAIL to_cnt got=%0d exp=67", stall_cnt); end
        #2 reset_n = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL to_reset_clears got=%b exp=%b", outs, 8'b1100_0000); end
        checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL to_reset_cnt got=%0d exp=0", stall_cnt); end
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_saturation;
        DX_MemToReg = 1'b1; DX_rd = 5'd7; FD_rs = 5'd7; #1;
        for (int k = 0; k < 254; k++) cyc();
        #1;
        checks++; if (stall_cnt !== 8'd254) begin failures++; $display("FAIL cnt_254 got=%0d exp=254", stall_cnt); end
        for (int k = 0; k < 11; k++) cyc();
        #1;
        checks++; if (stall_cnt !== 8'd255) begin failures++; $display("FAIL cnt_saturate got=%0d exp=255", stall_cnt); end
        idle_inputs();
        cyc(); #1;
        checks++; if (stall_cnt !== 8'd255) begin failures++; $display("FAIL cnt_hold got=%0d exp=255", stall_cnt); end
    endtask

    task automatic test_async_reset_busy;
        DX_isMult = 1'b1; #1;
        cyc();
        cyc(); #1;
        checks++; if (outs !== 8'b0000_0010) begin failures++; $display("FAIL ar_busy got=%b exp=%b", outs, 8'b0000_0010); end
        #2 reset_n = 1'b0; #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL ar_outputs got=%b exp=%b", outs, 8'b1100_0000); end
        checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL ar_cnt got=%0d exp=0", stall_cnt); end
        DX_isMult = 1'b0;
        @(negedge clock); reset_n = 1'b1; #1;
        cyc(); #1;
        checks++; if (outs !== 8'b1100_0000) begin failures++; $display("FAIL ar_stays_idle got=%b exp=%b", outs, 8'b1100_0000); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mult();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_async_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_stall_ctrl
